usb_crc16_append: RTL and testbench
===================================

# usb_crc16_append

Transmit-side stream stage between the encrypted byte FIFO and the transmitter control unit. AES encryption rewrites the DATA payload, so the CRC16 captured on receive no longer applies. This block passes each payload byte through unchanged, computes USB CRC16 over the bytes on the fly, and appends the two CRC bytes after the last payload byte. It also supports zero-length packets and flags payloads longer than the allowed maximum.

## Interface
- MAX_BYTES, default 64, largest legal payload length in bytes (full-speed bulk).
- clk  in  1  clock (transmitter clock domain)
- n_rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream byte valid
- in_ready  out  1  block accepts the byte this cycle
- in_data  in  8  payload byte
- in_last  in  1  qualifies the final payload byte of a packet
- zlp_req  in  1  single-cycle request to emit a zero-length packet (CRC only)
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts the output byte
- out_data  out  8  payload or CRC byte
- out_last  out  1  marks the high CRC byte (end of packet)
- busy  out  1  a packet is in progress (state is not IDLE)
- len_err  out  1  one-cycle pulse when a byte is accepted while the count already equals MAX_BYTES

## Operation
- States:
  - IDLE: no packet open.
  - DATA: packet open.
  - CRC_LO, CRC_HI: emitting the CRC bytes.
- Output register holds out_valid, out_data and out_last. Define load = !out_valid || out_ready.
- in_ready = (state is IDLE or DATA) && load. This is combinational and never depends on in_valid.
- On accept (in_valid && in_ready):
  - out_data <= in_data, out_valid <= 1, out_last <= 0.
  - crc <= crc16_next(base, in_data), where base = 16'hFFFF if state is IDLE, else crc.
  - count <= (IDLE ? 1 : count+1). Count saturates at MAX_BYTES.
  - Next state: CRC_LO if in_last, else DATA.
- len_err = accept && state==DATA && count==MAX_BYTES. The offending byte is still passed through. Framing is unaffected.
- CRC_LO && load: out_data <= ~crc[7:0], out_valid <= 1, out_last <= 0, go to CRC_HI.
- CRC_HI && load: out_data <= ~crc[15:8], out_valid <= 1, out_last <= 1, go to IDLE.
- If no byte is loaded and out_ready is high, out_valid <= 0.
- zlp_req is honoured only in IDLE with in_valid low: crc <= 16'hFFFF, go to CRC_LO. The two bytes emitted are 0x00, 0x00.
  - zlp_req together with in_valid in IDLE: the byte wins and zlp_req is dropped.
  - zlp_req outside IDLE: ignored.
- CRC arithmetic is CRC-16/USB:
  - polynomial x^16+x^15+x^2+1, reflected constant 16'hA001, bits processed LSB first;
  - init 16'hFFFF, final complement, low byte transmitted first.
- Reset value of every output: in_ready 1 (derived), out_valid 0, out_data 8'h00, out_last 0, busy 0, len_err 0. Internal state resets to IDLE, crc to 16'hFFFF, count to 0.
- Reset mid-packet discards the partial packet and the held output byte without completing the CRC. The next accepted byte starts a fresh packet.

## Timing
- Byte accepted at edge N appears on out_data from cycle N+1.
- Latency is 1 cycle. No combinational path runs from in_data to out_data.
- With out_ready held at 1, an N-byte packet occupies the output for N+2 consecutive cycles.
- in_ready is low for exactly the 2 CRC cycles. The next packet's first byte can be accepted on the cycle after CRC_HI loads.
- While out_valid && !out_ready, out_data and out_last hold stable and in_ready is 0.
- One CRC step (8 unrolled bit iterations) is computed combinationally within the accept cycle. It must close timing at the transmitter clock.

## Structure
- Shared package usb_pkg holds:
  - CRC16_POLY_REFL = 16'hA001
  - CRC16_INIT = 16'hFFFF
  - function crc16_next(input [15:0] crc, input [7:0] data) returning the updated CRC, reusable by the receive-side checker
  - enum crc_app_state_t {IDLE, DATA, CRC_LO, CRC_HI}
- No sub-module: one always_ff for state, output register, crc and count, plus one always_comb for in_ready/load/next-state.
- Count width: $clog2(MAX_BYTES+1).

## Test plan
- Bytes 0x31..0x39 ("123456789"), in_last on 0x39, out_ready=1:
  - the 9 bytes come out unchanged, then 0xC8, then 0xB4 with out_last=1;
  - in_ready is low for exactly 2 cycles; busy falls after 0xB4 loads.
- Same packet with out_ready toggling 1,0,1,0:
  - identical 11-byte sequence, with no byte lost or duplicated;
  - out_data stable whenever out_valid && !out_ready.
- The packet above sent twice back-to-back with in_valid held high: both packets end in 0xC8, 0xB4, which shows the CRC is re-initialised. Total 22 output cycles.
- zlp_req pulse in IDLE: outputs 0x00 then 0x00 with out_last on the second. A zlp_req issued while in DATA is ignored.
- MAX_BYTES=64, 65 bytes 0x00..0x40 with in_last on the 65th: len_err pulses exactly on acceptance of byte 0x40, and all 65 bytes plus 2 CRC bytes are still emitted.
- Assert n_rst after 4 bytes of a packet: all outputs take their reset values. Then "123456789" yields 0xC8, 0xB4.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB definitions: CRC16 constants, per-byte CRC update and the
// state encoding of the transmit-side CRC append stage.
package usb_pkg;

  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC_LO,
    CRC_HI
  } crc_app_state_t;

  // One byte of reflected CRC-16/USB, LSB of the data byte first.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY_REFL;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16_append.sv
// Transmit stream stage: forwards payload bytes through a one-deep output
// register and appends the complemented CRC16 (low byte first) at packet end.
module usb_crc16_append
  import usb_pkg::*;
#(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       zlp_req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       len_err
);

  localparam int                CNT_W   = $clog2(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BYTES);

  crc_app_state_t   state, state_nxt;
  logic [15:0]      crc;
  logic [15:0]      crc_base;
  logic [15:0]      crc_upd;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             load;
  logic             accept;
  logic             zlp_go;

  always_comb begin
    load      = !out_valid || out_ready;
    in_ready  = ((state == IDLE) || (state == DATA)) && load;
    accept    = in_valid && in_ready;
    // A byte presented together with zlp_req takes priority.
    zlp_go    = (state == IDLE) && zlp_req && !in_valid;
    len_err   = accept && (state == DATA) && (count == MAX_CNT);
    busy      = (state != IDLE);

    crc_base  = (state == IDLE) ? CRC16_INIT : crc;
    crc_upd   = crc16_next(crc_base, in_data);

    if (state == IDLE)         count_nxt = CNT_W'(1);
    else if (count == MAX_CNT) count_nxt = count;
    else                       count_nxt = count + CNT_W'(1);

    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept)      state_nxt = in_last ? CRC_LO : DATA;
        else if (zlp_go) state_nxt = CRC_LO;
      end
      DATA: begin
        if (accept) state_nxt = in_last ? CRC_LO : DATA;
      end
      CRC_LO: begin
        if (load) state_nxt = CRC_HI;
      end
      CRC_HI: begin
        if (load) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      crc       <= CRC16_INIT;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        crc   <= crc_upd;
        count <= count_nxt;
      end else if (zlp_go) begin
        crc <= CRC16_INIT;
      end

      // Output register: payload byte, then ~crc low, then ~crc high.
      if (accept) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
        out_last  <= 1'b0;
      end else if ((state == CRC_LO) && load) begin
        out_data  <= ~crc[7:0];
        out_valid <= 1'b1;
        out_last  <= 1'b0;
      end else if ((state == CRC_HI) && load) begin
        out_data  <= ~crc[15:8];
        out_valid <= 1'b1;
        out_last  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_crc16_append.sv
// Scoreboard bench for usb_crc16_append: expected bytes are queued as stimulus
// is accepted and compared when the output handshake fires.
module tb_usb_crc16_append;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       zlp_req = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       len_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];
  bit         tog_en = 1'b0;
  int         cyc = 0;
  int         fire_cnt = 0;
  int         first_fire = -1;
  int         last_fire = -1;
  bit         rdy_win = 1'b0;
  int         rdy_low = 0;
  bit         stall_prev = 1'b0;
  logic [8:0] held = '0;

  usb_crc16_append #(.MAX_BYTES(64)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .zlp_req   (zlp_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [7:0] b[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[k]) begin
      for (int i = 0; i < 8; i++) begin
        if (c[0] ^ b[k][i]) c = (c >> 1) ^ 16'hA001;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // Downstream back-pressure pattern, changed just after each active edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    out_ready = tog_en ? ~out_ready : 1'b1;
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (rdy_win && !in_ready) rdy_low++;
    if (stall_prev && out_valid) check("hold", {23'd0, out_last, out_data}, {23'd0, held});
    stall_prev = out_valid && !out_ready;
    held = {out_last, out_data};
    if (stall_prev) check("rdy_stall", {31'd0, in_ready}, 32'd0);
    if (out_valid && out_ready) begin
      fire_cnt++;
      if (first_fire < 0) first_fire = cyc;
      last_fire = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_out", {23'd0, out_last, out_data}, 32'h1FF);
      end else begin
        e = exp_q.pop_front();
        check("out", {23'd0, out_last, out_data}, {23'd0, e});
        if (e[8]) check("busy_end", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input logic exp_err);
    int t;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    check("len_err", {31'd0, len_err}, {31'd0, exp_err});
    exp_q.push_back({1'b0, d});
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] b[$], input logic [7:0] lo, input logic [7:0] hi,
                          input int err_idx, input bit hold_valid);
    foreach (b[k]) send_byte(b[k], (k == b.size() - 1), (k == err_idx));
    exp_q.push_back({1'b0, lo});
    exp_q.push_back({1'b1, hi});
    if (!hold_valid) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 32'd0);
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"},  {24'd0, out_data},  32'd0);
    check({tag, "_out_last"},  {31'd0, out_last},  32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_len_err"},   {31'd0, len_err},   32'd0);
  endtask

  initial begin
    logic [7:0]  str[$];
    logic [7:0]  big[$];
    logic [15:0] c;

    for (int i = 0; i < 9; i++) str.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 65; i++) big.push_back(8'(i));

    #2 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst0");
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // "123456789" with free-running output.
    rdy_win = 1'b1;
    rdy_low = 0;
    send_pkt(str, 8'hC8, 8'hB4, -1, 1'b0);
    wait_drain();
    rdy_win = 1'b0;
    check("rdy_low_cycles", rdy_low, 32'd2);

    // Same packet with downstream toggling.
    tog_en = 1'b1;
    send_pkt(str, 8'hC8, 8'hB4, -1, 1'b0);
    wait_drain();
    tog_en = 1'b0;
    @(posedge clk);
    #1;

    // Two packets back to back, in_valid never dropped.
    fire_cnt   = 0;
    first_fire = -1;
    send_pkt(str, 8'hC8, 8'hB4, -1, 1'b1);
    send_pkt(str, 8'hC8, 8'hB4, -1, 1'b0);
    wait_drain();
    check("b2b_count", fire_cnt, 32'd22);
    check("b2b_span", last_fire - first_fire + 1, 32'd22);

    // Zero-length packet from IDLE.
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    zlp_req = 1'b1;
    @(posedge clk);
    #1;
    zlp_req = 1'b0;
    wait_drain();

    // zlp_req alongside the first byte, and again mid-packet: both dropped.
    zlp_req = 1'b1;
    send_byte(8'h31, 1'b0, 1'b0);
    zlp_req = 1'b0;
    in_valid = 1'b0;
    zlp_req = 1'b1;
    @(posedge clk);
    #1;
    zlp_req = 1'b0;
    check("zlp_in_data_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i < 9; i++) send_byte(str[i], (i == 8), 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_q.push_back({1'b0, 8'hC8});
    exp_q.push_back({1'b1, 8'hB4});
    wait_drain();

    // Oversized packet: 65 bytes, error on the 65th.
    c = ref_crc(big);
    send_pkt(big, c[7:0], c[15:8], 64, 1'b0);
    wait_drain();

    // Reset in the middle of a packet.
    for (int i = 0; i < 4; i++) send_byte(str[i], 1'b0, 1'b0);
    in_valid = 1'b0;
    n_rst = 1'b0;
    exp_q.delete();
    #2;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(str, 8'hC8, 8'hB4, -1, 1'b0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
